fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 129 ++++++++++++
 tb/tb_fetch_stage.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch front end.
// Issues word-aligned reads to a fixed one-cycle-latency instruction memory and
// buffers the returned words, tagged with their fetch address, in a 4-entry FIFO
// that feeds the decode stage.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   redirect_valid/_pc  replace the fetch PC (flushes buffered and in-flight words)
//   imem_req/_addr      memory read request and word address
//   imem_rdata          memory read data, one cycle after imem_req
//   valid_output        FIFO head holds an instruction
//   data_output         head instruction word
//   pc_output           head fetch address
//   stall_input         downstream does not accept the head this cycle
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        valid_output,
  output logic [31:0] data_output,
  output logic [31:0] pc_output,
  input  logic        stall_input
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned PTR_W = 2;
  localparam int unsigned CNT_W = 3;

  logic [XLEN-1:0]  pc_q, pc_d;
  logic             pending_q, pending_d;
  logic [XLEN-1:0]  pend_addr_q, pend_addr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [XLEN-1:0]  instr_q [DEPTH];
  logic [XLEN-1:0]  ipc_q   [DEPTH];

  logic req, push, pop;

  // Next-state logic; a redirect overrides push, pop and stall.
  always_comb begin
    req         = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    pc_d        = pc_q;
    pending_d   = 1'b0;
    pend_addr_d = pend_addr_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;

    if (redirect_valid) begin
      // The response arriving now belongs to the old stream and is dropped.
      pc_d     = redirect_pc & ~XLEN'(3);
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Outstanding request counts against capacity so its response always fits.
      req  = rst && ((count_q + CNT_W'(pending_q)) < CNT_W'(DEPTH));
      push = pending_q;
      pop  = (count_q != '0) && !stall_input;

      if (req) begin
        pc_d        = pc_q + XLEN'(4);
        pend_addr_d = pc_q;
      end
      pending_d = req;

      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q        <= RESET_PC;
      pending_q   <= 1'b0;
      pend_addr_q <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      pc_q        <= pc_d;
      pending_q   <= pending_d;
      pend_addr_q <= pend_addr_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
    end
  end

  // FIFO storage; cleared on reset so the head reads zero while in reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        ipc_q[i]   <= '0;
      end
    end else if (push) begin
      instr_q[wr_ptr_q] <= imem_rdata;
      ipc_q[wr_ptr_q]   <= pend_addr_q;
    end
  end

  assign imem_req     = req;
  assign imem_addr    = pc_q;
  assign valid_output = (count_q != '0);
  assign data_output  = instr_q[rd_ptr_q];
  assign pc_output    = ipc_q[rd_ptr_q];

  // A push into a full FIFO would mean the capacity gate on req is broken.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(push && (count_q == CNT_W'(DEPTH))));

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus randomized stall/redirect traffic,
// checked against a queue-based reference model of the fetch stage.
module tb_fetch_stage;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        valid_output;
  logic [31:0] data_output;
  logic [31:0] pc_output;
  logic        stall_input = 1'b0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .valid_output(valid_output), .data_output(data_output), .pc_output(pc_output),
    .stall_input(stall_input)
  );

  // Reference model: buffered {data, pc} in order, next fetch address, outstanding request.
  logic [63:0] mq[$];
  logic [31:0] m_pc;
  bit          m_pend;
  logic [31:0] m_pend_addr;
  // Memory environment.
  bit          mem_out;
  logic [31:0] mem_addr;
  // Consumption log.
  bit          have_last;
  logic [31:0] last_pc;
  logic [31:0] popped[$];

  int tests = 0;
  int fails = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hA5A5_A5A5;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic step(input bit stall, input bit redir, input logic [31:0] rpc);
    bit exp_req, exp_valid, pop;
    @(negedge clk);
    stall_input    = stall;
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_rdata     = mem_out ? memf(mem_addr) : $urandom();
    #1;
    exp_req = !redir && ((mq.size() + int'(m_pend)) < 4);
    check("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
    if (exp_req) check("imem_addr", imem_addr, m_pc);
    exp_valid = (mq.size() != 0);
    check("valid_output", {31'b0, valid_output}, {31'b0, exp_valid});
    if (exp_valid) begin
      check("pc_output", pc_output, mq[0][31:0]);
      check("data_output", data_output, mq[0][63:32]);
    end
    pop = exp_valid && !stall && !redir;
    if (pop) begin
      if (have_last) check("order", pc_output, last_pc + 32'd4);
      check("data_vs_mem", data_output, memf(pc_output));
      have_last = 1'b1;
      last_pc   = pc_output;
      popped.push_back(pc_output);
    end
    mem_out  = imem_req;
    mem_addr = imem_addr;
    if (redir) begin
      mq.delete();
      m_pc      = {rpc[31:2], 2'b00};
      m_pend    = 1'b0;
      have_last = 1'b0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (m_pend) mq.push_back({imem_rdata, m_pend_addr});
      if (exp_req) begin
        m_pend_addr = m_pc;
        m_pc        = m_pc + 32'd4;
      end
      m_pend = exp_req;
    end
  endtask

  // Assert reset asynchronously, check outputs, release mid high phase.
  task automatic do_reset();
    rst = 1'b0;
    #1;
    check("rst_valid", {31'b0, valid_output}, 32'd0);
    check("rst_data", data_output, 32'd0);
    check("rst_pc", pc_output, 32'd0);
    check("rst_req", {31'b0, imem_req}, 32'd0);
    mq.delete();
    m_pc      = RPC;
    m_pend    = 1'b0;
    mem_out   = 1'b0;
    have_last = 1'b0;
    popped.delete();
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_valid", {31'b0, valid_output}, 32'd0);
    check("rst_hold_req", {31'b0, imem_req}, 32'd0);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    logic [31:0] held;

    // Reset release and initial fill.
    do_reset();
    step(0, 0, 0);
    check("first_req", {31'b0, imem_req}, 32'd1);
    check("first_addr", imem_addr, RPC);
    step(0, 0, 0);
    check("valid_c1", {31'b0, valid_output}, 32'd0);
    step(0, 0, 0);
    check("valid_c2", {31'b0, valid_output}, 32'd1);
    repeat (10) step(0, 0, 0);
    check("seq0", popped[0], 32'h100);
    check("seq1", popped[1], 32'h104);
    check("seq2", popped[2], 32'h108);

    // Stall for 10 cycles: FIFO fills to 4, requests stop, head holds.
    held = last_pc + 32'd4;
    repeat (10) step(1, 0, 0);
    check("stall_req_low", {31'b0, imem_req}, 32'd0);
    check("stall_valid", {31'b0, valid_output}, 32'd1);
    check("stall_head", pc_output, held);
    check("stall_model_full", mq.size(), 32'd4);
    popped.delete();
    repeat (8) step(0, 0, 0);
    check("drain_count", {31'b0, popped.size() >= 4}, 32'd1);
    check("drain_first", popped[0], held);

    // Redirect while one request is outstanding and three words are buffered.
    repeat (3) step(0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      if (mq.size() == 3 && m_pend) break;
      step(1, 0, 0);
    end
    check("reach_c3p1", {31'b0, (mq.size() == 3 && m_pend)}, 32'd1);
    step(0, 1, 32'h2003);
    step(0, 0, 0);
    check("redir_valid_low", {31'b0, valid_output}, 32'd0);
    popped.delete();
    repeat (6) step(0, 0, 0);
    check("redir_first_pc", popped[0], 32'h2000);

    // Address wrap.
    step(0, 1, 32'hFFFF_FFF8);
    popped.delete();
    repeat (8) step(0, 0, 0);
    check("wrap0", popped[0], 32'hFFFF_FFF8);
    check("wrap1", popped[1], 32'hFFFF_FFFC);
    check("wrap2", popped[2], 32'h0000_0000);

    // Asynchronous reset mid-stream with two words buffered.
    for (int i = 0; i < 10; i++) begin
      if (mq.size() == 2) break;
      step(1, 0, 0);
    end
    check("reach_c2", mq.size(), 32'd2);
    #2;
    do_reset();
    repeat (6) step(0, 0, 0);
    check("restart_pc", popped[0], RPC);

    // Random stall/redirect traffic.
    for (int n = 0; n < 4000; n++) begin
      bit s, r;
      s = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 15) == 0);
      step(s, r, $urandom());
    end
    repeat (6) step(0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
